lsu_mem_access: RTL

Multi-cycle load/store execution unit that sits directly downstream of the load/store decode stage in the RISC-V core. It accepts one memory operation at a time, as a load/store flag, the funct3 width code, an address and store data. It drives a word-addressed 32-bit data-memory bus with byte enables, splits word-crossing accesses into two bus beats, and returns sign- or zero-extended load data. The pipeline stalls on `req_ready` low.

---
 rtl/lsu_mem_access.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - multi-cycle RISC-V load/store unit driving a word-addressed 32-bit data bus
// Optional macro LSU_MISALIGN_SPLIT_EN: word-crossing accesses run as two bus beats instead of erroring.
module lsu_mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_started;
    logic              r_load, r_uns, r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_lo;
    logic [3:0]        r_mask;
    logic [2:0]        w_nbytes;
    logic [3:0]        w_mask;
    logic              w_legal, w_cross, w_accept;
    logic [23:0]       w_hi;
    logic [31:0]       w_raw, w_ext;
    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_word;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              r_cross;
    logic [23:0]       r_hi;
    assign w_hi = r_hi;
`else
    assign w_hi = 24'd0;
`endif

    assign w_off    = r_addr[1:0];
    assign w_word   = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_accept = (r_state == IDLE) && r_started && req_valid;

    always_comb begin
        w_nbytes = 3'd4;
        w_mask   = 4'b1111;
        case (req_func3[1:0])
            2'b00:   begin w_nbytes = 3'd1; w_mask = 4'b0001; end
            2'b01:   begin w_nbytes = 3'd2; w_mask = 4'b0011; end
            default: begin w_nbytes = 3'd4; w_mask = 4'b1111; end
        endcase
        w_legal = req_load ? (req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (req_func3 inside {3'b000, 3'b001, 3'b010});
        w_cross = ({1'b0, req_addr[1:0]} + w_nbytes) > 3'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    w_next = w_legal ? BEAT0 : RESP;
`else
                    w_next = (w_legal && !w_cross) ? BEAT0 : RESP;
`endif
                end
            end
            BEAT0: begin
                if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    w_next = r_cross ? BEAT1 : RESP;
`else
                    w_next = RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: if (mem_ack) w_next = RESP;
`endif
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load  <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_lo    <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross <= 1'b0;
            r_hi    <= 24'd0;
`endif
        end else if (w_accept) begin
            r_load  <= req_load;
            r_uns   <= req_func3[2];
            r_size  <= req_func3[1:0];
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= w_mask;
            r_lo    <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_err   <= !w_legal;
            r_cross <= w_cross;
            r_hi    <= 24'd0;
`else
            r_err   <= !w_legal || w_cross;
`endif
        end else if (r_state == BEAT0 && mem_ack && r_load) begin
            r_lo <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        end else if (r_state == BEAT1 && mem_ack && r_load) begin
            r_hi <= mem_rdata[23:0];
`endif
        end
    end

    // Only hi[23:0] can ever reach the result window, since off is 3 at most.
    always_comb begin
        w_raw = r_lo;
        case (w_off)
            2'd1:    w_raw = {w_hi[7:0],  r_lo[31:8]};
            2'd2:    w_raw = {w_hi[15:0], r_lo[31:16]};
            2'd3:    w_raw = {w_hi[23:0], r_lo[31:24]};
            default: w_raw = r_lo;
        endcase
        w_ext = w_raw;
        case (r_size)
            2'b00:   w_ext = r_uns ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
            2'b01:   w_ext = r_uns ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE) && r_started;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = w_word;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        case (r_state)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_we    = !r_load;
                mem_be    = r_mask << w_off;
                mem_wdata = r_wdata << {w_off, 3'b000};
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: begin
                mem_req  = 1'b1;
                mem_we   = !r_load;
                mem_addr = w_word + ADDR_W'(4);
                mem_be   = r_mask >> (3'd4 - {1'b0, w_off});
                case (w_off)
                    2'd1:    mem_wdata = {24'd0, r_wdata[31:24]};
                    2'd2:    mem_wdata = {16'd0, r_wdata[31:16]};
                    default: mem_wdata = {8'd0,  r_wdata[31:8]};
                endcase
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_load && !r_err) ? w_ext : 32'd0;
            end
            default: ;
        endcase
    end
endmodule
